// File: rtl/mux2_arb_ctrl_if.sv
// Handshake and data bundle between mux2_arb_ctrl, its two sources, the select mux and the downstream sink.
interface mux2_arb_ctrl_if #(
  parameter int unsigned M     = 4,
  parameter int unsigned CNT_W = 8
);
  logic             A_valid;
  logic             A_ready;
  logic             B_valid;
  logic             B_ready;
  logic             S;
  logic [M:0]       Y;
  logic [M:0]       Q;
  logic             Q_valid;
  logic             Q_ready;
  logic [CNT_W-1:0] cnt_A;
  logic [CNT_W-1:0] cnt_B;

  modport master (
    input  A_valid, B_valid, Y, Q_ready,
    output A_ready, B_ready, S, Q, Q_valid, cnt_A, cnt_B
  );

  modport slave (
    output A_valid, B_valid, Y, Q_ready,
    input  A_ready, B_ready, S, Q, Q_valid, cnt_A, cnt_B
  );
endinterface

// File: rtl/mux2_arb_ctrl.sv
// Round-robin arbiter and select driver for a 2:1 mux, with a one-deep registered output stage and grant counters.
// Optional macro MUX2_ARB_FIXED_PRIO_EN: A always wins ties (B may starve).
module mux2_arb_ctrl #(
  parameter int unsigned M     = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic            clk,
  input logic            rst,
  mux2_arb_ctrl_if.master bus
);
  localparam int unsigned DW = M + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_a;
  logic             grant_a;
  logic             grant_b;
  logic             sel;
  logic             space;
  logic             ld;
  logic [DW-1:0]    q;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  // Output stage state register
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Grant, select, load and next-state decode
  always_comb begin
    state_nxt = state;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    sel       = last_a;
    space     = 1'b0;
    ld        = 1'b0;

`ifdef MUX2_ARB_FIXED_PRIO_EN
    grant_a = bus.A_valid;
`else
    grant_a = bus.A_valid && (!bus.B_valid || !last_a);
`endif
    grant_b = bus.B_valid && !grant_a;

    // Select follows the grant even while stalled; idles on the last winner
    if (grant_a)      sel = 1'b1;
    else if (grant_b) sel = 1'b0;

    space = (state == EMPTY) || bus.Q_ready;
    ld    = !rst && space && (grant_a || grant_b);

    if (ld)                                  state_nxt = FULL;
    else if (state == FULL && bus.Q_ready)   state_nxt = EMPTY;
  end

  // Captured data, last-grant pointer and saturating counters
  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= '0;
      last_a <= 1'b0;
      cnt_a  <= '0;
      cnt_b  <= '0;
    end else if (ld) begin
      q      <= bus.Y;
      last_a <= grant_a;
      if (grant_a && cnt_a != {CNT_W{1'b1}}) cnt_a <= cnt_a + CNT_W'(1);
      if (grant_b && cnt_b != {CNT_W{1'b1}}) cnt_b <= cnt_b + CNT_W'(1);
    end
  end

  assign bus.S       = sel;
  assign bus.A_ready = ld && grant_a;
  assign bus.B_ready = ld && grant_b;
  assign bus.Q       = q;
  assign bus.Q_valid = (state == FULL);
  assign bus.cnt_A   = cnt_a;
  assign bus.cnt_B   = cnt_b;
endmodule

// File: tb/tb_mux2_arb_ctrl.sv
// Self-checking bench for mux2_arb_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_mux2_arb_ctrl;
  localparam int unsigned M     = 4;
  localparam int unsigned CNT_W = 8;
  localparam int          CMAX  = 255;
`ifdef MUX2_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [M:0] a_data;
  logic [M:0] b_data;
  int         n_checks = 0;
  int         n_errors = 0;

  mux2_arb_ctrl_if #(.M(M), .CNT_W(CNT_W)) bus ();

  mux2_arb_ctrl #(.M(M), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // The mux being controlled
  assign bus.Y = bus.S ? a_data : b_data;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.A_valid = 1'b0;
    bus.B_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Behavioural model: state as it stands after the most recent clock edge
  bit m_init = 1'b0;
  bit m_full;
  int m_q;
  bit m_last_a;
  int m_ca;
  int m_cb;

  always @(negedge clk) begin
    bit av, bv, qr, ga, gb, ld, es;
    av = bus.A_valid;
    bv = bus.B_valid;
    qr = bus.Q_ready;
    ga = av && (!bv || FIXED || !m_last_a);
    gb = bv && !ga;
    es = ga ? 1'b1 : (gb ? 1'b0 : m_last_a);
    ld = !rst && (!m_full || qr) && (ga || gb);
    if (m_init) begin
      check("S",       32'(bus.S),       32'(es));
      check("A_ready", 32'(bus.A_ready), 32'(ld && ga));
      check("B_ready", 32'(bus.B_ready), 32'(ld && gb));
      check("Q_valid", 32'(bus.Q_valid), 32'(m_full));
      check("Q",       32'(bus.Q),       32'(m_q));
      check("cnt_A",   32'(bus.cnt_A),   32'(m_ca));
      check("cnt_B",   32'(bus.cnt_B),   32'(m_cb));
    end
    if (rst) begin
      m_init = 1'b1; m_full = 1'b0; m_q = 0; m_last_a = 1'b0; m_ca = 0; m_cb = 0;
    end else if (ld) begin
      m_q      = ga ? int'(a_data) : int'(b_data);
      m_full   = 1'b1;
      m_last_a = ga;
      if (ga) m_ca = (m_ca >= CMAX) ? CMAX : m_ca + 1;
      else    m_cb = (m_cb >= CMAX) ? CMAX : m_cb + 1;
    end else if (m_full && qr) begin
      m_full = 1'b0;
    end
  end

  initial begin
    logic [M:0] rr_exp [4];
    rst = 1'b1;
    a_data = '0;
    b_data = '0;
    bus.A_valid = 1'b0;
    bus.B_valid = 1'b0;
    bus.Q_ready = 1'b0;

    // Reset then idle
    do_reset();
    #1;
    check("rst_Q",       32'(bus.Q), 32'h0);
    check("rst_Q_valid", 32'(bus.Q_valid), 32'h0);
    check("rst_S",       32'(bus.S), 32'h0);
    check("rst_cnt_A",   32'(bus.cnt_A), 32'h0);
    check("rst_cnt_B",   32'(bus.cnt_B), 32'h0);
    check("rst_readies", 32'({bus.A_ready, bus.B_ready}), 32'h0);
    tick();

    // Single A transfer
    a_data = 5'h15;
    bus.A_valid = 1'b1;
    bus.Q_ready = 1'b1;
    #1;
    check("single_S",       32'(bus.S), 32'h1);
    check("single_A_ready", 32'(bus.A_ready), 32'h1);
    tick();
    bus.A_valid = 1'b0;
    check("single_Q",       32'(bus.Q), 32'h15);
    check("single_Q_valid", 32'(bus.Q_valid), 32'h1);
    check("single_cnt_A",   32'(bus.cnt_A), 32'h1);
    tick();

    // Tie handling from a fresh pointer
    do_reset();
    a_data = 5'h0A;
    b_data = 5'h11;
    rr_exp[0] = 5'h0A;
    rr_exp[1] = FIXED ? 5'h0A : 5'h11;
    rr_exp[2] = 5'h0A;
    rr_exp[3] = FIXED ? 5'h0A : 5'h11;
    bus.A_valid = 1'b1;
    bus.B_valid = 1'b1;
    bus.Q_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("tie_Q%0d", i), 32'(bus.Q), 32'(rr_exp[i]));
    end
    bus.A_valid = 1'b0;
    bus.B_valid = 1'b0;
    check("tie_cnt_A", 32'(bus.cnt_A), FIXED ? 32'd4 : 32'd2);
    check("tie_cnt_B", 32'(bus.cnt_B), FIXED ? 32'd0 : 32'd2);
    tick();

    // Backpressure
    do_reset();
    b_data = 5'h03;
    a_data = 5'h07;
    bus.B_valid = 1'b1;
    bus.Q_ready = 1'b1;
    tick();
    bus.B_valid = 1'b0;
    bus.Q_ready = 1'b0;
    bus.A_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_Q",       32'(bus.Q), 32'h03);
      check("bp_Q_valid", 32'(bus.Q_valid), 32'h1);
      check("bp_A_ready", 32'(bus.A_ready), 32'h0);
      check("bp_S",       32'(bus.S), 32'h1);
      tick();
    end
    bus.Q_ready = 1'b1;
    #1;
    check("bp_release_A_ready", 32'(bus.A_ready), 32'h1);
    tick();
    bus.A_valid = 1'b0;
    check("bp_release_Q", 32'(bus.Q), 32'h07);

    // Counter saturation
    do_reset();
    bus.A_valid = 1'b1;
    bus.Q_ready = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    check("sat_cnt_A", 32'(bus.cnt_A), 32'd255);
    check("sat_cnt_B", 32'(bus.cnt_B), 32'd0);

    // Reset mid-operation while holding data
    a_data = 5'h1F;
    tick();
    bus.Q_ready = 1'b0;
    check("mid_Q_before", 32'(bus.Q), 32'h1F);
    rst = 1'b1;
    #1;
    check("mid_A_ready", 32'(bus.A_ready), 32'h0);
    tick();
    rst = 1'b0;
    bus.A_valid = 1'b0;
    check("mid_Q_valid", 32'(bus.Q_valid), 32'h0);
    check("mid_Q",       32'(bus.Q), 32'h0);
    check("mid_cnt_A",   32'(bus.cnt_A), 32'h0);
    tick();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      a_data      = M'($urandom);
      b_data      = (M + 1)'($urandom);
      bus.A_valid = ($urandom_range(0, 3) != 0);
      bus.B_valid = ($urandom_range(0, 2) != 0);
      bus.Q_ready = ($urandom_range(0, 3) != 0);
      rst         = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    bus.A_valid = 1'b0;
    bus.B_valid = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mux2_arb_ctrl.md
Name: mux2_arb_ctrl

Overview:
- Control stage that sits directly in front of the M+1-bit 2:1 select mux.
- Arbitrates between two valid/ready source streams (A side, B side) and drives the mux select S.
- Captures the mux output Y into a one-deep registered output stage with valid/ready handshake.
- Keeps per-side grant counters for debug/perf.

Parameters:
M, 4, data MSB index; data width is M+1 bits (matches the mux)
CNT_W, 8, width of each saturating grant counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
A_valid  input  1  A-side source has data on mux input A
A_ready  output  1  A-side data consumed this cycle
B_valid  input  1  B-side source has data on mux input B
B_ready  output  1  B-side data consumed this cycle
S  output  1  mux select; 1 = A, 0 = B
Y  input  M+1  mux output, fed back combinationally from the mux
Q  output  M+1  registered output data
Q_valid  output  1  Q holds valid data
Q_ready  input  1  downstream accepts Q this cycle
cnt_A  output  CNT_W  number of A grants, saturating
cnt_B  output  CNT_W  number of B grants, saturating

Behaviour:
- Reset (sync, rst=1 at posedge):
  - Q=0, Q_valid=0, cnt_A=0, cnt_B=0.
  - last-grant pointer = B, so A wins the first tie.
  - rst overrides all other activity in that cycle. A mid-transfer reset drops held Q data with no ready asserted.
- Output stage states:
  - EMPTY (Q_valid=0) and FULL (Q_valid=1).
  - space = EMPTY or (FULL and Q_ready).
- Grant (combinational, same cycle):
  - Only A_valid: grant A.
  - Only B_valid: grant B.
  - Both valid: grant the side that is not the last-grant pointer (round-robin).
  - Neither valid: no grant.
- Load: ld = space and (A_valid or B_valid).
- S drive:
  - S = 1 when grant A, 0 when grant B.
  - With no grant, S holds the last-grant pointer value (0 after reset), so S never toggles while idle.
  - S does not depend on space. It reflects the grant even while stalled, and the mux output stays stable.
- Ready outputs:
  - A_ready = ld and grant A.
  - B_ready = ld and grant B.
  - The two are never both 1.
- On posedge with ld:
  - Q <= Y (the value seen with S as driven that cycle).
  - Q_valid <= 1.
  - Last-grant pointer <= granted side.
  - Granted side's counter increments.
- On posedge with no ld:
  - FULL and Q_ready: Q_valid <= 0. Q keeps its stale value.
  - Otherwise hold.
- Latency and throughput:
  - 1 cycle from source handshake to Q_valid.
  - Sustained throughput is one transfer per cycle when Q_ready stays high.
  - Simultaneous drain and load in FULL stays FULL with the new data.
- Counters:
  - Saturate at 2^CNT_W-1 and never wrap.
  - Each counter increments only on its own side's handshake.
- Backpressure:
  - FULL and Q_ready=0 means ld=0 and both readies are 0.
  - Pointer and counters hold; Q is unchanged.
- No combinational path from Q_ready to S.
- Q_ready feeds A_ready/B_ready only.

Optional Feature:
- Macro: MUX2_ARB_FIXED_PRIO_EN.
- Defined:
  - When both sides are valid, A always wins.
  - Last-grant pointer is still updated (it drives idle S), but it is not used for tie-break.
  - B can starve under continuous A_valid.
- Undefined (default): round-robin tie-break as in Behaviour.

Test Plan:
- Bench models the mux as Y = S ? A : B, with M=4 and CNT_W=8.
- Reset, then idle:
  - rst=1 for 2 cycles, then A_valid=B_valid=0.
  - Expect Q=0, Q_valid=0, S=0, cnt_A=cnt_B=0, A_ready=B_ready=0.
- Single A transfer:
  - A=5'h15, A_valid=1 for one cycle, Q_ready=1.
  - Expect same cycle S=1, A_ready=1.
  - Next cycle expect Q=5'h15, Q_valid=1, cnt_A=1.
- Round-robin tie:
  - A=5'h0A, B=5'h11, both valid for 4 cycles, Q_ready=1.
  - Expect grants A,B,A,B; Q sequence 0A,11,0A,11; cnt_A=2, cnt_B=2.
  - With MUX2_ARB_FIXED_PRIO_EN: A,A,A,A and cnt_A=4.
- Backpressure:
  - Load 5'h03 from B, then Q_ready=0 for 3 cycles with A_valid=1.
  - Expect Q held at 03, Q_valid=1, A_ready=0, S=1 throughout.
  - Raising Q_ready loads A's data next edge.
- Saturation:
  - Force 300 A grants.
  - Expect cnt_A=255 (stays there), cnt_B=0.
- Reset mid-operation:
  - rst=1 while FULL with Q=5'h1F and A_valid=1.
  - Expect next edge Q_valid=0, Q=0, counters 0, A_ready=0 during reset.
